ec_result_collector: RTL and testbench

- Downstream of the error-correcting RNS product-sum engine (ec_prod_sum_*); consumes its per-result datavalid strobe, sign, four 16-bit binary words and error flags.
- Converts sign-magnitude to 65-bit two's complement, tags each result with batch/index and an error code, and buffers it in a FIFO with a valid/ready output handshake.
- Keeps saturating error statistics, plus batch and completion status for the host.

---
 rtl/ec_result_pkg.sv | 45 ++++
 rtl/ec_result_fifo.sv | 66 ++++++
 rtl/ec_result_collector.sv | 176 +++++++++++++++++
 tb/tb_ec_result_collector.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_result_pkg.sv
// Shared types for the result collector: error codes, FSM states, and the
// result payload, plus the sign-magnitude conversion and error encoding helpers.
package ec_result_pkg;

  localparam int unsigned RESULT_W = 65;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_COR    = 2'd1,
    ERR_NONCOR = 2'd2,
    ERR_MAL    = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Result payload; batch/index tags are appended by the collector because
  // their widths follow its parameters.
  typedef struct packed {
    logic [RESULT_W-1:0] result;
    err_code_e           err_code;
  } res_entry_t;

  // -0 negates to 0, so negative zero normalises without a special case.
  function automatic logic [RESULT_W-1:0] sm_to_twos(input logic                sign,
                                                     input logic [RESULT_W-2:0] mag);
    logic [RESULT_W-1:0] ext;
    ext = {1'b0, mag};
    return sign ? -ext : ext;
  endfunction

  // Malfunction outranks non-correctable, which outranks corrected.
  function automatic err_code_e encode_err(input logic cor, input logic non_cor,
                                           input logic mal);
    if (mal) return ERR_MAL;
    if (non_cor) return ERR_NONCOR;
    if (cor) return ERR_COR;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/ec_result_fifo.sv
// Synchronous shift-register FIFO. Entry 0 is the head, so the output is taken
// straight from a flop. A push into a full FIFO succeeds when a pop happens in
// the same cycle.
module ec_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     used_o
);

  localparam int unsigned UsedW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [UsedW-1:0] used_q, used_d;
  logic [UsedW-1:0] wr_idx;
  logic             do_pop, do_push;

  assign empty_o = (used_q == '0);
  assign full_o  = (used_q == UsedW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // A simultaneous pop shifts everything down one slot before the write lands.
  assign wr_idx  = do_pop ? used_q - UsedW'(1) : used_q;

  assign valid_o = ~empty_o;
  assign data_o  = mem_q[0];
  assign used_o  = used_q;

  // Next storage contents: shift on pop, then write the incoming entry at the tail.
  always_comb begin
    mem_d = mem_q;
    if (do_pop) begin
      for (int unsigned i = 0; i < Depth - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (do_push) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (UsedW'(i) == wr_idx) mem_d[i] = data_i;
      end
    end
    used_d = used_q + UsedW'(do_push) - UsedW'(do_pop);
  end

  // Storage and occupancy registers; reset discards all contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      used_q <= '0;
    end else begin
      mem_q  <= mem_d;
      used_q <= used_d;
    end
  end

endmodule

// File: rtl/ec_result_collector.sv
// Collects results from the error-correcting product-sum engine: converts them
// to two's complement, tags them with batch/index and error code, buffers them,
// and keeps saturating error statistics and run-completion status.
module ec_result_collector
  import ec_result_pkg::*;
#(
  parameter int unsigned NUM_PRODS   = 64,
  parameter int unsigned NUM_BATCHES = 7,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           s_clk,
  input  logic                           reset_n,
  input  logic                           datavalid_in,
  input  logic                           sign_in,
  input  logic [15:0]                    bin_in_1_,
  input  logic [15:0]                    bin_in_2_,
  input  logic [15:0]                    bin_in_3_,
  input  logic [15:0]                    bin_in_4_,
  input  logic                           cor_error_in,
  input  logic                           non_cor_error_in,
  input  logic                           mal_error_in,
  input  logic                           done_in,
  input  logic                           clr_stats,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RESULT_W-1:0]            result_out,
  output logic [1:0]                     err_code_out,
  output logic [$clog2(NUM_BATCHES)-1:0] batch_out,
  output logic [$clog2(NUM_PRODS)-1:0]   index_out,
  output logic [CNT_W-1:0]               cor_cnt,
  output logic [CNT_W-1:0]               non_cor_cnt,
  output logic [CNT_W-1:0]               mal_cnt,
  output logic                           overflow,
  output logic                           batch_done,
  output logic                           all_done,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_used
);

  localparam int unsigned BatchW = $clog2(NUM_BATCHES);
  localparam int unsigned IndexW = $clog2(NUM_PRODS);
  localparam int unsigned EntryW = $bits(res_entry_t) + BatchW + IndexW;

  logic [IndexW-1:0] index_q, index_d, index_tag;
  logic [BatchW-1:0] batch_q, batch_d, batch_tag;
  logic [CNT_W-1:0]  cor_q, cor_d, non_cor_q, non_cor_d, mal_q, mal_d;
  logic              ovf_q, ovf_d, bdone_q, bdone_d;
  state_e            state_q, state_d;

  err_code_e         code;
  res_entry_t        new_entry, head_entry;
  logic [EntryW-1:0] fifo_din, fifo_dout;
  logic              fifo_full, fifo_empty, pop;

  assign code      = encode_err(cor_error_in, non_cor_error_in, mal_error_in);
  assign pop       = out_valid & out_ready;
  // A clear coinciding with a strobe still pushes the entry, tagged as the first of a run.
  assign index_tag = clr_stats ? '0 : index_q;
  assign batch_tag = clr_stats ? '0 : batch_q;

  // Build the buffered entry from the current strobe.
  always_comb begin
    new_entry.result   = sm_to_twos(sign_in, {bin_in_4_, bin_in_3_, bin_in_2_, bin_in_1_});
    new_entry.err_code = code;
    fifo_din           = {new_entry, batch_tag, index_tag};
  end

  ec_result_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (s_clk),
    .rst_ni  (reset_n),
    .push_i  (datavalid_in),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .used_o  (fifo_used)
  );

  assign {head_entry, batch_out, index_out} = fifo_dout;
  assign result_out   = head_entry.result;
  assign err_code_out = head_entry.err_code;

  // Statistics and tag counters; they advance on every strobe, dropped or not.
  always_comb begin
    index_d   = index_q;
    batch_d   = batch_q;
    cor_d     = cor_q;
    non_cor_d = non_cor_q;
    mal_d     = mal_q;
    ovf_d     = ovf_q;
    bdone_d   = 1'b0;
    if (clr_stats) begin
      index_d   = '0;
      batch_d   = '0;
      cor_d     = '0;
      non_cor_d = '0;
      mal_d     = '0;
      ovf_d     = 1'b0;
    end else if (datavalid_in) begin
      if (index_q == IndexW'(NUM_PRODS - 1)) begin
        index_d = '0;
        bdone_d = 1'b1;
        batch_d = (batch_q == BatchW'(NUM_BATCHES - 1)) ? '0 : batch_q + BatchW'(1);
      end else begin
        index_d = index_q + IndexW'(1);
      end
      unique case (code)
        ERR_NONE:   ;
        ERR_COR:    if (cor_q != '1) cor_d = cor_q + CNT_W'(1);
        ERR_NONCOR: if (non_cor_q != '1) non_cor_d = non_cor_q + CNT_W'(1);
        ERR_MAL:    if (mal_q != '1) mal_d = mal_q + CNT_W'(1);
      endcase
      if (fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge s_clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q   <= '0;
      batch_q   <= '0;
      cor_q     <= '0;
      non_cor_q <= '0;
      mal_q     <= '0;
      ovf_q     <= 1'b0;
      bdone_q   <= 1'b0;
    end else begin
      index_q   <= index_d;
      batch_q   <= batch_d;
      cor_q     <= cor_d;
      non_cor_q <= non_cor_d;
      mal_q     <= mal_d;
      ovf_q     <= ovf_d;
      bdone_q   <= bdone_d;
    end
  end

  assign cor_cnt     = cor_q;
  assign non_cor_cnt = non_cor_q;
  assign mal_cnt     = mal_q;
  assign overflow    = ovf_q;
  assign batch_done  = bdone_q;

  // Run-state register.
  always_ff @(posedge s_clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Run-state transitions; DRAIN completes only once nothing is buffered or arriving.
  always_comb begin
    state_d = state_q;
    if (clr_stats) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (done_in) state_d = StDrain;
                 else if (datavalid_in) state_d = StRun;
        StRun:   if (done_in) state_d = StDrain;
        StDrain: if (fifo_empty && !datavalid_in) state_d = StDone;
        StDone:  if (datavalid_in) state_d = StRun;
      endcase
    end
  end

  // Completion status for the host.
  always_comb begin
    all_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_ec_result_collector.sv
// Scoreboard bench for ec_result_collector: a reference model predicts each
// accepted entry and the statistics; a monitor compares on every falling edge.
module tb_ec_result_collector;

  localparam int NP    = 64;
  localparam int NB    = 7;
  localparam int DEPTH = 8;

  logic        s_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        datavalid_in = 1'b0, sign_in = 1'b0;
  logic [15:0] bin_in_1_ = '0, bin_in_2_ = '0, bin_in_3_ = '0, bin_in_4_ = '0;
  logic        cor_error_in = 1'b0, non_cor_error_in = 1'b0, mal_error_in = 1'b0;
  logic        done_in = 1'b0, clr_stats = 1'b0, out_ready = 1'b0;
  logic        out_valid, overflow, batch_done, all_done;
  logic [64:0] result_out;
  logic [1:0]  err_code_out;
  logic [2:0]  batch_out;
  logic [5:0]  index_out;
  logic [15:0] cor_cnt, non_cor_cnt, mal_cnt;
  logic [3:0]  fifo_used;

  ec_result_collector dut (
    .s_clk            (s_clk),
    .reset_n          (reset_n),
    .datavalid_in     (datavalid_in),
    .sign_in          (sign_in),
    .bin_in_1_        (bin_in_1_),
    .bin_in_2_        (bin_in_2_),
    .bin_in_3_        (bin_in_3_),
    .bin_in_4_        (bin_in_4_),
    .cor_error_in     (cor_error_in),
    .non_cor_error_in (non_cor_error_in),
    .mal_error_in     (mal_error_in),
    .done_in          (done_in),
    .clr_stats        (clr_stats),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result_out       (result_out),
    .err_code_out     (err_code_out),
    .batch_out        (batch_out),
    .index_out        (index_out),
    .cor_cnt          (cor_cnt),
    .non_cor_cnt      (non_cor_cnt),
    .mal_cnt          (mal_cnt),
    .overflow         (overflow),
    .batch_done       (batch_done),
    .all_done         (all_done),
    .fifo_used        (fifo_used)
  );

  always #5 s_clk = ~s_clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [64:0] act,
                              input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [64:0] res;
    logic [1:0]  code;
    int          b;
    int          i;
  } exp_t;

  exp_t exp_q[$];
  int   m_n, m_cor, m_nc, m_mal;   // strobes since clear, per-code totals
  bit   m_ovf, m_bd;

  // Model update at each active edge, from the bench's own stimulus.
  always @(posedge s_clk or negedge reset_n) begin : model
    exp_t            e;
    logic [63:0]     mag;
    logic signed [64:0] v;
    if (!reset_n) begin
      exp_q.delete();
      m_n = 0; m_cor = 0; m_nc = 0; m_mal = 0; m_ovf = 0; m_bd = 0;
    end else begin
      m_bd = 0;
      if (datavalid_in) begin
        mag = {bin_in_4_, bin_in_3_, bin_in_2_, bin_in_1_};
        v = $signed({1'b0, mag});
        e.res  = sign_in ? 65'(-v) : 65'(v);
        e.code = mal_error_in ? 2'd3 : non_cor_error_in ? 2'd2 : cor_error_in ? 2'd1 : 2'd0;
        e.i    = clr_stats ? 0 : m_n % NP;
        e.b    = clr_stats ? 0 : (m_n / NP) % NB;
        // The monitor has already removed the entry leaving at this edge.
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else m_ovf = 1;
        if (!clr_stats) begin
          m_bd = ((m_n % NP) == NP - 1);
          m_n++;
          if (e.code == 2'd1) m_cor++;
          if (e.code == 2'd2) m_nc++;
          if (e.code == 2'd3) m_mal++;
        end
      end
      if (clr_stats) begin
        m_n = 0; m_cor = 0; m_nc = 0; m_mal = 0; m_ovf = 0;
      end
    end
  end

  // Monitor: compares DUT state against the model away from the active edge.
  always @(negedge s_clk) begin : monitor
    if (reset_n) begin
      chk("out_valid", 65'(out_valid), 65'(exp_q.size() != 0));
      chk("fifo_used", 65'(fifo_used), 65'(exp_q.size()));
      chk("cor_cnt", 65'(cor_cnt), 65'(sat(m_cor)));
      chk("non_cor_cnt", 65'(non_cor_cnt), 65'(sat(m_nc)));
      chk("mal_cnt", 65'(mal_cnt), 65'(sat(m_mal)));
      chk("overflow", 65'(overflow), 65'(m_ovf));
      chk("batch_done", 65'(batch_done), 65'(m_bd));
      chk("all_done_while_busy", 65'(all_done && exp_q.size() != 0), 65'(0));
      if (exp_q.size() != 0) begin
        chk("result", result_out, exp_q[0].res);
        chk("err_code", 65'(err_code_out), 65'(exp_q[0].code));
        chk("batch_tag", 65'(batch_out), 65'(exp_q[0].b));
        chk("index_tag", 65'(index_out), 65'(exp_q[0].i));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit dv, input bit sg, input logic [63:0] mag,
                       input logic [2:0] fl, input bit rdy, input bit clr, input bit dn);
    @(posedge s_clk);
    #1;
    datavalid_in = dv;
    sign_in      = sg;
    {bin_in_4_, bin_in_3_, bin_in_2_, bin_in_1_} = mag;
    {mal_error_in, non_cor_error_in, cor_error_in} = fl;
    out_ready = rdy;
    clr_stats = clr;
    done_in   = dn;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 1'b0, 64'd0, 3'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic rand_strobe(input bit rdy, input logic [2:0] fl);
    drive(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, fl, rdy, 1'b0, 1'b0);
  endtask

  initial begin : stim
    bit got;
    #12 reset_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    @(negedge s_clk);
    chk("rst_valid_used", {out_valid, fifo_used}, 65'd0);
    chk("rst_result", result_out, 65'd0);
    chk("rst_counts", {cor_cnt, non_cor_cnt, mal_cnt}, 65'd0);
    chk("rst_flags", {overflow, batch_done, all_done, batch_out, index_out}, 65'd0);

    // Word order and one-cycle latency
    drive(1'b1, 1'b0, 64'h4444_3333_2222_1111, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge s_clk);
    chk("word_order", result_out, 65'h0_4444_3333_2222_1111);
    chk("word_order_valid", 65'(out_valid), 65'd1);

    // Negation and negative zero
    drive(1'b1, 1'b1, 64'h5, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge s_clk);
    chk("neg_five", result_out, 65'h1_FFFF_FFFF_FFFF_FFFB);
    drive(1'b1, 1'b1, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge s_clk);
    chk("neg_zero", result_out, 65'd0);

    // Error priority
    rand_strobe(1'b1, 3'b001);
    idle(1'b1);
    @(negedge s_clk);
    chk("code_cor", 65'(err_code_out), 65'd1);
    rand_strobe(1'b1, 3'b011);
    idle(1'b1);
    @(negedge s_clk);
    chk("code_noncor", 65'(err_code_out), 65'd2);
    rand_strobe(1'b1, 3'b101);
    idle(1'b1);
    @(negedge s_clk);
    chk("code_mal", 65'(err_code_out), 65'd3);
    chk("counts_111", {cor_cnt, non_cor_cnt, mal_cnt}, {16'd1, 16'd1, 16'd1});

    // Overflow: nine strobes into eight slots
    idle(1'b1);
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) rand_strobe(1'b0, 3'd0);
    idle(1'b0);
    @(negedge s_clk);
    chk("ovf_used", 65'(fifo_used), 65'd8);
    chk("ovf_flag", 65'(overflow), 65'd1);
    // Full FIFO with a pop in the same cycle accepts the write
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    rand_strobe(1'b1, 3'd0);
    idle(1'b0);
    @(negedge s_clk);
    chk("full_pop_used", 65'(fifo_used), 65'd8);
    chk("full_pop_no_ovf", 65'(overflow), 65'd0);
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      @(negedge s_clk);
      chk("drain_index", 65'(index_out), 65'((k + 1) % 8));
    end
    idle(1'b1);

    // Batch wrap
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 450; i++) begin
      rand_strobe(1'b1, 3'($urandom_range(0, 7)));
      if (i == 64 || i == 448) begin
        @(negedge s_clk);
        chk("batch_done_pulse", 65'(batch_done), 65'd1);
      end
      if (i == 65) begin
        @(negedge s_clk);
        chk("batch_one", {batch_out, index_out}, {3'd1, 6'd0});
      end
      if (i == 449) begin
        @(negedge s_clk);
        chk("batch_wrap", {batch_out, index_out}, {3'd0, 6'd0});
      end
    end
    idle(1'b1);

    // Completion
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) rand_strobe(1'b0, 3'd0);
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge s_clk);
    chk("not_done_yet", 65'(all_done), 65'd0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      idle(1'b1);
      @(negedge s_clk);
      if (all_done) got = 1'b1;
    end
    chk("all_done_rise", 65'(got), 65'd1);
    chk("all_done_drained", 65'(fifo_used), 65'd0);
    rand_strobe(1'b1, 3'd0);
    idle(1'b1);
    @(negedge s_clk);
    chk("all_done_cleared", 65'(all_done), 65'd0);

    // Clear coinciding with a strobe
    idle(1'b1);
    rand_strobe(1'b0, 3'b001);
    rand_strobe(1'b0, 3'b001);
    drive(1'b1, 1'b0, 64'h1234, 3'b100, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge s_clk);
    chk("clr_counts", {cor_cnt, non_cor_cnt, mal_cnt}, 65'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      @(negedge s_clk);
    end
    chk("clr_entry_tag", {batch_out, index_out, err_code_out}, {3'd0, 6'd0, 2'd3});
    idle(1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0));
    end
    for (int k = 0; k < 10; k++) idle(1'b1);

    // Counter saturation
    drive(1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 65540; k++) drive(1'b1, 1'b0, 64'd7, 3'b001, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge s_clk);
    chk("cor_saturated", 65'(cor_cnt), 65'hFFFF);

    // Asynchronous reset mid-burst
    for (int k = 0; k < 4; k++) rand_strobe(1'b0, 3'b010);
    @(posedge s_clk);
    #3 reset_n = 1'b0;
    datavalid_in = 1'b0;
    #1;
    chk("arst_valid_used", {out_valid, fifo_used}, 65'd0);
    chk("arst_result", result_out, 65'd0);
    chk("arst_counts", {cor_cnt, non_cor_cnt, mal_cnt}, 65'd0);
    chk("arst_flags", {overflow, batch_done, all_done, err_code_out, batch_out, index_out},
        65'd0);
    #20;
    @(negedge s_clk);
    #1 reset_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    @(negedge s_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
